// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester, response and APB master signal bundle
// Purpose: groups the command handshake, completion strobe and APB bus of
//          apb_master_arbiter into one interface.
// Signals:
//   req_valid/req_ready/req_write      per-requester command handshake
//   req_addr/req_wdata                 packed per-requester fields, slice i = [i*W +: W]
//   rsp_valid/rsp_id/rsp_rdata         one-cycle completion strobe and read data
//   rsp_err/rsp_timeout                completion status
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB request side
//   PREADY/PRDATA/PSLVERR              APB completer response
// Modports: master = arbiter side, slave = requesters plus APB completer.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;

  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;

  logic                      PSEL;
  logic                      PENABLE;
  logic                      PWRITE;
  logic [ADDR_W-1:0]         PADDR;
  logic [DATA_W-1:0]         PWDATA;
  logic                      PREADY;
  logic [DATA_W-1:0]         PRDATA;
  logic                      PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin arbiter sharing one APB master port
// Purpose: grants single-beat commands from NUM_REQ requesters round-robin,
//          runs APB SETUP/ACCESS with wait states and an optional watchdog,
//          and reports completion on a registered one-cycle response strobe.
// Ports:
//   PCLK    in   clock
//   PRESET  in   asynchronous active-high reset
//   bus     apb_master_arbiter_if.master (requests, responses, APB bus)
module apb_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_arbiter_if.master bus
);
  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last permitted ACCESS cycle; it was cleared on
  // ACCESS entry, so the TIMEOUT-th waited cycle is where it aborts.
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    cur_id;
  logic               cmd_write;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [CNT_W-1:0]   wd_cnt;

  logic               rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [DATA_W-1:0]  rsp_rdata_q;

  logic               timeout_hit, complete, accept_win, take;
  logic               grant_any;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] ready;
  logic               psel, penable, pwrite;

  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !bus.PREADY && (wd_cnt == WD_LAST);
  assign complete    = (state == ACCESS) && (bus.PREADY || timeout_hit);
  assign accept_win  = (state == IDLE) || complete;
  assign take        = accept_win && grant_any;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin : arb
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (take) ready[grant_idx] = 1'b1;
  end
  assign bus.req_ready = ready;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = take ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    case (state)
      SETUP:  begin psel = 1'b1; pwrite = cmd_write; end
      ACCESS: begin psel = 1'b1; penable = 1'b1; pwrite = cmd_write; end
      default: ;
    endcase
  end

  // Command latch; PADDR/PWDATA keep their last values while idle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rr_ptr    <= '0;
      cur_id    <= '0;
      cmd_write <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else if (take) begin
      rr_ptr    <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      cur_id    <= grant_idx;
      cmd_write <= bus.req_write[grant_idx];
      paddr_q   <= bus.req_addr[int'(grant_idx) * ADDR_W +: ADDR_W];
      pwdata_q  <= bus.req_wdata[int'(grant_idx) * DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                 wd_cnt <= '0;
    else if (state != ACCESS)   wd_cnt <= '0;
    else if (!bus.PREADY)       wd_cnt <= wd_cnt + CNT_W'(1);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q <= complete;
      if (complete) begin
        rsp_id_q      <= cur_id;
        rsp_err_q     <= timeout_hit || bus.PSLVERR;
        rsp_timeout_q <= timeout_hit;
        rsp_rdata_q   <= (cmd_write || timeout_hit) ? '0 : bus.PRDATA;
      end
    end
  end

  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PWRITE      = pwrite;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  apb_master_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  // Every step lands 2 time units after a rising edge; checks happen at +3.
  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = '0;
    bus.PSLVERR   = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    bus.req_valid[i]        = v;
    bus.req_write[i]        = w;
    bus.req_addr[i*AW +: AW] = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin n_bad++; $display("FAIL reset_ctrl: got %b want 000", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    n_cmp++; if (bus.PADDR !== 32'h0) begin n_bad++; $display("FAIL reset_paddr: got %h want 0", bus.PADDR); end
    n_cmp++; if (bus.PWDATA !== 32'h0) begin n_bad++; $display("FAIL reset_pwdata: got %h want 0", bus.PWDATA); end
    n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_rsp: got %b want 000", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}); end
    n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.rsp_rdata); end
    n_cmp++; if (bus.req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    bus.PREADY = 1'b1;
    bus.PRDATA = 32'hCAFE0001;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL rd_ready: got %b want 0001", bus.req_ready); end
    cycle();
    bus.req_valid[0] = 1'b0;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b100) begin n_bad++; $display("FAIL rd_setup: got %b want 100", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    n_cmp++; if (bus.PADDR !== 32'h10) begin n_bad++; $display("FAIL rd_paddr: got %h want 10", bus.PADDR); end
    cycle();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin n_bad++; $display("FAIL rd_access: got %b want 110", {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
    cycle();
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_rsp_valid: got %b want 1", bus.rsp_valid); end
    n_cmp++; if ({bus.rsp_id, bus.rsp_err, bus.rsp_timeout} !== 4'b0000) begin n_bad++; $display("FAIL rd_rsp_status: got %b want 0000", {bus.rsp_id, bus.rsp_err, bus.rsp_timeout}); end
    n_cmp++; if (bus.rsp_rdata !== 32'hCAFE0001) begin n_bad++; $display("FAIL rd_rdata: got %h want cafe0001", bus.rsp_rdata); end
    n_cmp++; if (bus.PSEL !== 1'b0) begin n_bad++; $display("FAIL rd_idle_psel: got %b want 0", bus.PSEL); end
    cycle();
    #1;
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_pulse: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_round_robin();
    int exp_id;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'hD000_0000 + 32'(i));
    bus.PREADY = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_first: got %b want 0001", bus.req_ready); end
    for (int k = 0; k < 6; k++) begin
      exp_id = k % NR;
      cycle();
      #1;
      n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101) begin n_bad++; $display("FAIL rr_setup_%0d: got %b want 101", k, {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
      n_cmp++; if (bus.PWDATA !== 32'hD000_0000 + 32'(exp_id)) begin n_bad++; $display("FAIL rr_pwdata_%0d: got %h want %h", k, bus.PWDATA, 32'hD000_0000 + 32'(exp_id)); end
      n_cmp++; if (bus.PADDR !== 32'h100 + 32'(exp_id * 4)) begin n_bad++; $display("FAIL rr_paddr_%0d: got %h want %h", k, bus.PADDR, 32'h100 + 32'(exp_id * 4)); end
      if (k > 0) begin
        n_cmp++; if ({bus.rsp_valid, 2'(bus.rsp_id)} !== {1'b1, 2'((k - 1) % NR)}) begin n_bad++; $display("FAIL rr_rsp_%0d: got %b want %b", k, {bus.rsp_valid, bus.rsp_id}, {1'b1, 2'((k - 1) % NR)}); end
      end
      cycle();
      #1;
      n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin n_bad++; $display("FAIL rr_access_%0d: got %b want 11", k, {bus.PSEL, bus.PENABLE}); end
      n_cmp++; if (bus.req_ready !== 4'(1 << ((k + 1) % NR))) begin n_bad++; $display("FAIL rr_grant_%0d: got %b want %b", k + 1, bus.req_ready, 4'(1 << ((k + 1) % NR))); end
    end
  endtask

  task automatic test_wait_err();
    do_reset();
    set_req(2, 1'b1, 1'b1, 32'h44, 32'h5A5A_0044);
    bus.PRDATA = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL we_ready: got %b want 0100", bus.req_ready); end
    cycle();
    bus.req_valid[2] = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      cycle();
      if (a == 4) begin bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; end
      #1;
      n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid} !== 4'b1110) begin n_bad++; $display("FAIL we_access_%0d: got %b want 1110", a, {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid}); end
      n_cmp++; if ({bus.PADDR, bus.PWDATA} !== {32'h44, 32'h5A5A_0044}) begin n_bad++; $display("FAIL we_stable_%0d: got %h %h want 44 5a5a0044", a, bus.PADDR, bus.PWDATA); end
    end
    cycle();
    bus.PREADY = 1'b0;
    bus.PSLVERR = 1'b0;
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b110) begin n_bad++; $display("FAIL we_rsp: got %b want 110", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}); end
    n_cmp++; if ({bus.rsp_id, bus.rsp_rdata} !== {2'd2, 32'h0}) begin n_bad++; $display("FAIL we_rsp_data: got %h %h want 2 0", bus.rsp_id, bus.rsp_rdata); end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
    bus.PRDATA = 32'hBAD0_BAD0;
    cycle();
    bus.req_valid[1] = 1'b0;
    cycle();
    for (int a = 1; a <= TO; a++) begin
      #1;
      n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid} !== 3'b110) begin n_bad++; $display("FAIL wd_wait_%0d: got %b want 110", a, {bus.PSEL, bus.PENABLE, bus.rsp_valid}); end
      cycle();
    end
    #1;
    n_cmp++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout} !== 3'b111) begin n_bad++; $display("FAIL wd_rsp: got %b want 111", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout}); end
    n_cmp++; if ({bus.rsp_id, bus.rsp_rdata} !== {2'd1, 32'h0}) begin n_bad++; $display("FAIL wd_rsp_data: got %h %h want 1 0", bus.rsp_id, bus.rsp_rdata); end
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin n_bad++; $display("FAIL wd_idle: got %b want 00", {bus.PSEL, bus.PENABLE}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, 1'b1, 1'b0, 32'h80, 32'h0);
    cycle();
    bus.req_valid[2] = 1'b0;
    cycle();
    cycle();
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 2'b11) begin n_bad++; $display("FAIL rm_pre: got %b want 11", {bus.PSEL, bus.PENABLE}); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE} !== 2'b00) begin n_bad++; $display("FAIL rm_async: got %b want 00", {bus.PSEL, bus.PENABLE}); end
    bus.PREADY = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      #1;
      n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_rsp_%0d: got %b want 0", c, bus.rsp_valid); end
    end
    cycle();
    rst = 1'b0;
    set_req(1, 1'b1, 1'b0, 32'h11, 32'h0);
    set_req(3, 1'b1, 1'b0, 32'h33, 32'h0);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL rm_ptr: got %b want 0010", bus.req_ready); end
    cycle();
    bus.req_valid[1] = 1'b0;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PADDR} !== {1'b1, 32'h11}) begin n_bad++; $display("FAIL rm_setup: got %b %h want 1 11", bus.PSEL, bus.PADDR); end
    n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_rsp_setup: got %b want 0", bus.rsp_valid); end
    cycle();
    #1;
    n_cmp++; if (bus.req_ready !== 4'b1000) begin n_bad++; $display("FAIL rm_next: got %b want 1000", bus.req_ready); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
    bus.PREADY = 1'b1;
    cycle();
    bus.req_valid[0] = 1'b0;
    cycle();
    set_req(1, 1'b1, 1'b1, 32'h204, 32'h1111_2222);
    #1;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL sim_ready: got %b want 0010", bus.req_ready); end
    cycle();
    bus.req_valid[1] = 1'b0;
    #1;
    n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101) begin n_bad++; $display("FAIL sim_setup: got %b want 101", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
    n_cmp++; if ({bus.PADDR, bus.PWDATA} !== {32'h204, 32'h1111_2222}) begin n_bad++; $display("FAIL sim_fields: got %h %h want 204 11112222", bus.PADDR, bus.PWDATA); end
    n_cmp++; if ({bus.rsp_valid, bus.rsp_id} !== {1'b1, 2'd0}) begin n_bad++; $display("FAIL sim_rsp: got %b want 100", {bus.rsp_valid, bus.rsp_id}); end
  endtask

  // Transaction-level reference: a grant in cycle g puts SETUP in g+1 and
  // ACCESS in g+2..c, where c is when this bench (as completer) raises
  // PREADY; the response is due in c+1.
  task automatic test_random();
    logic [31:0] mem [16];
    logic        pend [NR];
    logic        pw [NR];
    logic [31:0] pa [NR];
    logic [31:0] pd [NR];
    int          ptr, win, idx, g_cyc, c_cyc, r_cyc, cid, r_id;
    logic        inflight, cw, cerr, comp, r_err;
    logic [31:0] ca, cd, r_data;
    logic [3:0]  exp_ready;
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
    ptr = 0; inflight = 1'b0; g_cyc = -10; c_cyc = -10; r_cyc = -10; cid = 0; r_id = 0;
    cw = 1'b0; cerr = 1'b0; r_err = 1'b0; ca = '0; cd = '0; r_data = '0;
    for (int cyc = 0; cyc < 420; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && cyc < 380 && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pw[i]   = 1'($urandom_range(0, 1));
          pa[i]   = 32'($urandom_range(0, 15) * 4);
          pd[i]   = $urandom;
        end
        set_req(i, pend[i], pw[i], pa[i], pd[i]);
      end
      comp = inflight && (cyc == c_cyc);
      bus.PREADY  = comp;
      bus.PSLVERR = comp && cerr;
      bus.PRDATA  = comp ? mem[ca[5:2]] : $urandom;
      win = -1;
      if (!inflight || comp) begin
        for (int k = 0; k < NR; k++) begin
          idx = (ptr + k) % NR;
          if (win < 0 && pend[idx]) win = idx;
        end
      end
      exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0000;
      #1;
      n_cmp++; if (bus.req_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, bus.req_ready, exp_ready); end
      if (inflight) begin
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== {1'b1, cyc != g_cyc + 1, cw}) begin n_bad++; $display("FAIL rnd_ctrl c%0d: got %b want %b", cyc, {bus.PSEL, bus.PENABLE, bus.PWRITE}, {1'b1, cyc != g_cyc + 1, cw}); end
        n_cmp++; if (bus.PADDR !== ca || (cw && bus.PWDATA !== cd)) begin n_bad++; $display("FAIL rnd_fields c%0d: got %h %h want %h %h", cyc, bus.PADDR, bus.PWDATA, ca, cd); end
      end else begin
        n_cmp++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b000) begin n_bad++; $display("FAIL rnd_idle c%0d: got %b want 000", cyc, {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
      end
      n_cmp++; if (bus.rsp_valid !== (cyc == r_cyc)) begin n_bad++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", cyc, bus.rsp_valid, cyc == r_cyc); end
      if (cyc == r_cyc) begin
        n_cmp++; if ({bus.rsp_id, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== {2'(r_id), r_err, 1'b0, r_data}) begin n_bad++; $display("FAIL rnd_rsp c%0d: got %h %b %b %h want %h %b 0 %h", cyc, bus.rsp_id, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata, r_id, r_err, r_data); end
      end
      if (comp) begin
        r_cyc  = cyc + 1;
        r_id   = cid;
        r_err  = cerr;
        r_data = cw ? 32'h0 : mem[ca[5:2]];
        if (cw && !cerr) mem[ca[5:2]] = cd;
        inflight = 1'b0;
      end
      if (win >= 0) begin
        inflight  = 1'b1;
        g_cyc     = cyc;
        c_cyc     = cyc + 2 + int'($urandom_range(0, 3));
        cerr      = ($urandom_range(0, 7) == 0);
        cid       = win;
        cw        = pw[win];
        ca        = pa[win];
        cd        = pd[win];
        pend[win] = 1'b0;
        ptr       = (win + 1) % NR;
      end
      cycle();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_err();
    test_watchdog();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
